// File: rtl/ase_tid_latency_pipe_if.sv
// ase_tid_latency_pipe_if: push, release and status bundle of the tid latency pipe.
// tid_load/tid_load_val preset the transaction-ID counter (bring-up and wrap testing).
`ifndef CCIP_TX_HDR_WIDTH
`define CCIP_TX_HDR_WIDTH 99
`endif
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 3:0
`endif
interface ase_tid_latency_pipe_if #(
    parameter int HDR_WIDTH  = `CCIP_TX_HDR_WIDTH,
    parameter int DATA_WIDTH = 512,
    parameter int TID_WIDTH  = 32
);
    logic                  valid_in;
    logic [HDR_WIDTH-1:0]  meta_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic [TID_WIDTH-1:0]  tid_in;
    logic                  full;
    logic                  almfull;
    logic                  stall_in;
    logic                  valid_out;
    logic [HDR_WIDTH-1:0]  meta_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic [TID_WIDTH-1:0]  tid_out;
    logic                  fence_done;
    logic                  ovf_err;
    logic                  tid_load;
    logic [TID_WIDTH-1:0]  tid_load_val;
    modport master (
        output valid_in, meta_in, data_in, stall_in, tid_load, tid_load_val,
        input  tid_in, full, almfull, valid_out, meta_out, data_out, tid_out, fence_done, ovf_err
    );
    modport slave (
        input  valid_in, meta_in, data_in, stall_in, tid_load, tid_load_val,
        output tid_in, full, almfull, valid_out, meta_out, data_out, tid_out, fence_done, ovf_err
    );
endinterface

// File: rtl/ase_tid_latency_pipe.sv
// ase_tid_latency_pipe: tags TX requests with sequential tids and releases them in order after a latency.
// Define ASE_TID_LAT_RANDOM_EN to add an LFSR-driven random extra latency per entry.
`ifndef CCIP_TX_HDR_WIDTH
`define CCIP_TX_HDR_WIDTH 99
`endif
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 3:0
`endif
module ase_tid_latency_pipe #(
    parameter int         HDR_WIDTH      = `CCIP_TX_HDR_WIDTH,
    parameter int         DATA_WIDTH     = 512,
    parameter int         TID_WIDTH      = 32,
    parameter int         DEPTH_BASE2    = 4,
    parameter int         ALMFULL_THRESH = 4,
    parameter int         MIN_LAT        = 4,
    parameter int         LAT_RANGE_LOG2 = 3,
    parameter logic [3:0] FENCE_TYPE     = 4'h4
) (
    input logic                   clk,
    input logic                   rst,
    ase_tid_latency_pipe_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_BASE2;
    localparam int CW    = $clog2(MIN_LAT + (1 << LAT_RANGE_LOG2) + 1);
    localparam int PW    = DEPTH_BASE2 + 1;
    logic [HDR_WIDTH-1:0]   meta_q [DEPTH];
    logic [DATA_WIDTH-1:0]  data_q [DEPTH];
    logic [TID_WIDTH-1:0]   tid_mem_q [DEPTH];
    logic                   fence_q [DEPTH];
    logic [CW-1:0]          lat_q [DEPTH];
    logic [DEPTH_BASE2-1:0] wr_q, rd_q;
    logic [PW-1:0]          count_q, count_d;
    logic [TID_WIDTH-1:0]   tid_q, tid_d, tid_out_q;
    logic [HDR_WIDTH-1:0]   meta_out_q;
    logic [DATA_WIDTH-1:0]  data_out_q;
    logic                   valid_out_q, fence_done_q, ovf_q;
    logic                   push, pop, is_fence, head_fence;
    logic [CW-1:0]          lat;
`ifdef ASE_TID_LAT_RANDOM_EN
    logic [15:0]            lfsr_q, lfsr_d;
`endif
    assign bus.full       = count_q == PW'(DEPTH);
    assign bus.almfull    = PW'(DEPTH) - count_q <= PW'(ALMFULL_THRESH);
    assign bus.tid_in     = tid_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.meta_out   = meta_out_q;
    assign bus.data_out   = data_out_q;
    assign bus.tid_out    = tid_out_q;
    assign bus.fence_done = fence_done_q;
    assign bus.ovf_err    = ovf_q;
    always_comb begin
        push       = bus.valid_in && !bus.full;
        is_fence   = bus.meta_in[`TX_META_TYPERANGE] == FENCE_TYPE;
        head_fence = fence_q[rd_q];
        // the cycle after a fence retires is a bubble, so nothing younger leaves before fence_done
        pop        = count_q != '0 && lat_q[rd_q] == '0 && !bus.stall_in && !fence_done_q;
        count_d    = count_q + PW'(push) - PW'(pop);
        tid_d      = bus.tid_load ? bus.tid_load_val : tid_q + TID_WIDTH'(push && !is_fence);
`ifdef ASE_TID_LAT_RANDOM_EN
        lfsr_d     = push ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]} : lfsr_q;
        lat        = CW'(MIN_LAT - 1) + CW'(lfsr_q[LAT_RANGE_LOG2-1:0]);
`else
        lat        = CW'(MIN_LAT - 1);
`endif
    end
    // entry storage needs no reset: count_q alone decides which slots are live
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            lat_q[i] <= (push && wr_q == DEPTH_BASE2'(i)) ? lat : (lat_q[i] != '0 ? lat_q[i] - 1'b1 : '0);
        if (push) begin
            meta_q[wr_q]    <= bus.meta_in;
            data_q[wr_q]    <= bus.data_in;
            tid_mem_q[wr_q] <= tid_q;
            fence_q[wr_q]   <= is_fence;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            tid_q        <= '0;
            valid_out_q  <= 1'b0;
            fence_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            meta_out_q   <= '0;
            data_out_q   <= '0;
            tid_out_q    <= '0;
`ifdef ASE_TID_LAT_RANDOM_EN
            lfsr_q       <= 16'h1;
`endif
        end else begin
            wr_q         <= wr_q + DEPTH_BASE2'(push);
            rd_q         <= rd_q + DEPTH_BASE2'(pop);
            count_q      <= count_d;
            tid_q        <= tid_d;
            valid_out_q  <= pop && !head_fence;
            fence_done_q <= pop && head_fence;
            ovf_q        <= ovf_q || (bus.valid_in && bus.full);
`ifdef ASE_TID_LAT_RANDOM_EN
            lfsr_q       <= lfsr_d;
`endif
            if (pop && !head_fence) begin
                meta_out_q <= meta_q[rd_q];
                data_out_q <= data_q[rd_q];
                tid_out_q  <= tid_mem_q[rd_q];
            end
        end
    end
endmodule

// File: tb/tb_ase_tid_latency_pipe.sv
// tb_ase_tid_latency_pipe: scenario tasks against a queue-based release-time model of the pipe.
module tb_ase_tid_latency_pipe;
    localparam int HW = 99, DW = 512, TW = 32, DEPTH = 16, MIN_LAT = 4;
    localparam logic [3:0] T_WRLINE = 4'h1, T_FENCE = 4'h4;
`ifdef ASE_TID_LAT_RANDOM_EN
    localparam int NR = 1500;
`else
    localparam int NR = 400;
`endif
    logic clk = 1'b0, rst = 1'b0;
    int passed = 0, total = 0;
    always #5 clk = ~clk;
    ase_tid_latency_pipe_if #(.HDR_WIDTH(HW), .DATA_WIDTH(DW), .TID_WIDTH(TW)) bus ();
    ase_tid_latency_pipe #(.HDR_WIDTH(HW), .DATA_WIDTH(DW), .TID_WIDTH(TW)) dut (.clk(clk), .rst(rst), .bus(bus));
    // model: each entry remembers the edge at which it may leave; the head leaves at the first edge at or after that
    typedef struct { logic [TW-1:0] tid; logic [HW-1:0] meta; logic [DW-1:0] data; bit fence; longint rel; } ent_t;
    ent_t q[$];
    longint n_edge = 0;
    logic [TW-1:0] m_tid = '0, m_tido = '0;
    logic [HW-1:0] m_meta = '0;
    logic [DW-1:0] m_data = '0;
    logic [15:0] m_lfsr = 16'h1;
    bit m_vo = 0, m_fd = 0, m_ovf = 0;
    always @(posedge clk) begin
        bit full_pre, pop;
        ent_t e;
        n_edge++;
        if (rst) begin
            q.delete(); m_tid = '0; m_tido = '0; m_meta = '0; m_data = '0;
            m_vo = 0; m_fd = 0; m_ovf = 0; m_lfsr = 16'h1;
        end else begin
            full_pre = q.size() == DEPTH;
            pop = 0;
            if (q.size() != 0) pop = !bus.stall_in && !m_fd && n_edge >= q[0].rel;
            m_vo = pop && !q[0].fence;
            m_fd = pop && q[0].fence;
            if (m_vo) begin m_tido = q[0].tid; m_meta = q[0].meta; m_data = q[0].data; end
            if (pop) void'(q.pop_front());
            if (bus.valid_in && full_pre) m_ovf = 1;
            else if (bus.valid_in) begin
                e.fence = bus.meta_in[3:0] == T_FENCE;
                e.tid = m_tid; e.meta = bus.meta_in; e.data = bus.data_in;
`ifdef ASE_TID_LAT_RANDOM_EN
                e.rel = n_edge + MIN_LAT + longint'(m_lfsr[2:0]);
                m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hD008)};
`else
                e.rel = n_edge + MIN_LAT;
`endif
                q.push_back(e);
                if (!e.fence) m_tid = m_tid + 1'b1;
            end
            if (bus.tid_load) m_tid = bus.tid_load_val;
        end
    end
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    function automatic logic [HW-1:0] mk_meta(bit fence);
        logic [HW-1:0] m = HW'({$urandom, $urandom, $urandom, $urandom});
        m[3:0] = fence ? T_FENCE : T_WRLINE;
        return m;
    endfunction
    function automatic logic [DW-1:0] mk_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction
    task automatic push1(bit fence);
        bus.valid_in = 1'b1; bus.meta_in = mk_meta(fence); bus.data_in = mk_data();
        tick();
        bus.valid_in = 1'b0;
    endtask
    task automatic drain(int n);
        bus.valid_in = 1'b0; bus.stall_in = 1'b0;
        repeat (n) tick();
    endtask
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(); tick();
        total++; if ({bus.valid_out, bus.fence_done, bus.ovf_err, bus.full, bus.almfull} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {bus.valid_out, bus.fence_done, bus.ovf_err, bus.full, bus.almfull}); else passed++;
        total++; if (bus.tid_out !== '0 || bus.meta_out !== '0 || bus.data_out !== '0) $display("FAIL reset_outs: tid_out %h meta_out %h want 0", bus.tid_out, bus.meta_out); else passed++;
        total++; if (bus.tid_in !== '0) $display("FAIL reset_tid_in: got %h want 0", bus.tid_in); else passed++;
        rst = 1'b0;
        tick();
    endtask
    task automatic test_single();
        logic [HW-1:0] m = mk_meta(0);
        logic [DW-1:0] d = mk_data();
        bus.valid_in = 1'b1; bus.meta_in = m; bus.data_in = d;
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            total++; if (bus.valid_out !== (i == 4)) $display("FAIL single_valid_%0d: got %b want %b", i, bus.valid_out, i == 4); else passed++;
            if (i == 4) begin
                total++; if (bus.tid_out !== 32'h0) $display("FAIL single_tid: got %h want 0", bus.tid_out); else passed++;
                total++; if (bus.meta_out !== m) $display("FAIL single_meta: got %h want %h", bus.meta_out, m); else passed++;
                total++; if (bus.data_out !== d) $display("FAIL single_data: got %h want %h", bus.data_out[63:0], d[63:0]); else passed++;
            end
            tick();
        end
    endtask
    task automatic test_overflow();
        logic [DW-1:0] ds[$];
        logic [TW-1:0] t0 = m_tid;
        bus.stall_in = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            logic [DW-1:0] d = mk_data();
            if (n <= 16) ds.push_back(d);
            bus.valid_in = 1'b1; bus.meta_in = mk_meta(0); bus.data_in = d;
            tick();
            total++; if (bus.full !== (n >= 16)) $display("FAIL ovf_full_%0d: got %b want %b", n, bus.full, n >= 16); else passed++;
            total++; if (bus.almfull !== (n >= 12)) $display("FAIL ovf_almfull_%0d: got %b want %b", n, bus.almfull, n >= 12); else passed++;
            total++; if (bus.ovf_err !== (n >= 17)) $display("FAIL ovf_err_%0d: got %b want %b", n, bus.ovf_err, n >= 17); else passed++;
        end
        bus.valid_in = 1'b0;
        tick();
        bus.stall_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++; if (bus.valid_out !== 1'b1 || bus.tid_out !== TW'(t0 + i)) $display("FAIL ovf_out_%0d: valid %b tid %h want 1 %h", i, bus.valid_out, bus.tid_out, TW'(t0 + i)); else passed++;
            total++; if (bus.data_out !== ds[i]) $display("FAIL ovf_data_%0d: got %h want %h", i, bus.data_out[63:0], ds[i][63:0]); else passed++;
        end
        tick();
        total++; if (bus.valid_out !== 1'b0) $display("FAIL ovf_tail: got %b want 0", bus.valid_out); else passed++;
    endtask
    task automatic test_fence();
        int ev[$];
        logic [TW-1:0] t0 = m_tid;
        push1(0); push1(1); push1(0);
        total++; if (bus.tid_in !== TW'(t0 + 2)) $display("FAIL fence_tid_in: got %h want %h", bus.tid_in, TW'(t0 + 2)); else passed++;
        for (int c = 0; c < 12; c++) begin
            total++; if (bus.valid_out !== m_vo || bus.fence_done !== m_fd) $display("FAIL fence_cycle_%0d: vo %b fd %b want %b %b", c, bus.valid_out, bus.fence_done, m_vo, m_fd); else passed++;
            if (bus.valid_out) ev.push_back(int'(bus.tid_out - t0));
            if (bus.fence_done) ev.push_back(9);
            tick();
        end
        total++; if (ev.size() !== 3) $display("FAIL fence_events: got %0d want 3", ev.size()); else passed++;
        if (ev.size() == 3) begin
            total++; if (ev[0] !== 0 || ev[1] !== 9 || ev[2] !== 1) $display("FAIL fence_order: got %0d %0d %0d want 0 9 1", ev[0], ev[1], ev[2]); else passed++;
        end
    endtask
    task automatic test_stall();
        logic [TW-1:0] t0 = m_tid;
        bus.stall_in = 1'b1;
        push1(0); push1(0); push1(0);
        for (int c = 0; c < 10; c++) begin
            total++; if (bus.valid_out !== 1'b0) $display("FAIL stall_hold_%0d: got %b want 0", c, bus.valid_out); else passed++;
            tick();
        end
        bus.stall_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.valid_out !== (i < 3)) $display("FAIL stall_rel_%0d: got %b want %b", i, bus.valid_out, i < 3); else passed++;
            if (i < 3) begin
                total++; if (bus.tid_out !== TW'(t0 + i)) $display("FAIL stall_tid_%0d: got %h want %h", i, bus.tid_out, TW'(t0 + i)); else passed++;
            end
        end
    endtask
    task automatic test_wrap();
        logic [TW-1:0] want[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
        logic [TW-1:0] got[$];
        bus.tid_load = 1'b1; bus.tid_load_val = 32'hFFFF_FFFE;
        tick();
        bus.tid_load = 1'b0;
        total++; if (bus.tid_in !== 32'hFFFF_FFFE) $display("FAIL wrap_preset: got %h want fffffffe", bus.tid_in); else passed++;
        push1(0); push1(0); push1(0);
        for (int c = 0; c < 8; c++) begin
            if (bus.valid_out) got.push_back(bus.tid_out);
            tick();
        end
        total++; if (got.size() !== 3) $display("FAIL wrap_count: got %0d want 3", got.size()); else passed++;
        for (int i = 0; i < got.size() && i < 3; i++) begin
            total++; if (got[i] !== want[i]) $display("FAIL wrap_tid_%0d: got %h want %h", i, got[i], want[i]); else passed++;
        end
        total++; if (bus.tid_in !== 32'h1) $display("FAIL wrap_tid_in: got %h want 1", bus.tid_in); else passed++;
    endtask
    task automatic test_random();
        for (int c = 0; c < NR; c++) begin
            bus.valid_in = $urandom_range(0, 9) < 7;
            bus.meta_in = mk_meta($urandom_range(0, 9) == 0);
            bus.data_in = mk_data();
            bus.stall_in = $urandom_range(0, 3) == 0;
            tick();
            total++; if (bus.valid_out !== m_vo || bus.fence_done !== m_fd) $display("FAIL rnd_pulse_%0d: vo %b fd %b want %b %b", c, bus.valid_out, bus.fence_done, m_vo, m_fd); else passed++;
            total++; if (bus.full !== (q.size() == DEPTH) || bus.almfull !== (DEPTH - q.size() <= 4)) $display("FAIL rnd_level_%0d: full %b almfull %b entries %0d", c, bus.full, bus.almfull, q.size()); else passed++;
            total++; if (bus.ovf_err !== m_ovf || bus.tid_in !== m_tid) $display("FAIL rnd_state_%0d: ovf %b tid_in %h want %b %h", c, bus.ovf_err, bus.tid_in, m_ovf, m_tid); else passed++;
            if (m_vo) begin
                total++; if (bus.tid_out !== m_tido || bus.meta_out !== m_meta || bus.data_out !== m_data) $display("FAIL rnd_out_%0d: tid %h want %h", c, bus.tid_out, m_tido); else passed++;
            end
        end
        drain(40);
    endtask
    task automatic test_reset_mid();
        bus.stall_in = 1'b1;
        repeat (5) push1(0);
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.stall_in = 1'b0;
        total++; if ({bus.full, bus.almfull, bus.ovf_err} !== 3'b0 || bus.tid_in !== '0) $display("FAIL rstmid_state: flags %b tid_in %h want 000 0", {bus.full, bus.almfull, bus.ovf_err}, bus.tid_in); else passed++;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++; if (bus.valid_out !== 1'b0 || bus.fence_done !== 1'b0) $display("FAIL rstmid_quiet_%0d: vo %b fd %b want 0 0", c, bus.valid_out, bus.fence_done); else passed++;
        end
        push1(0);
        for (int i = 0; i <= 6; i++) begin
            total++; if (bus.valid_out !== (i == 4)) $display("FAIL rstmid_valid_%0d: got %b want %b", i, bus.valid_out, i == 4); else passed++;
            if (i == 4) begin
                total++; if (bus.tid_out !== 32'h0) $display("FAIL rstmid_tid: got %h want 0", bus.tid_out); else passed++;
            end
            tick();
        end
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        bus.valid_in = 1'b0; bus.meta_in = '0; bus.data_in = '0;
        bus.stall_in = 1'b0; bus.tid_load = 1'b0; bus.tid_load_val = '0;
        test_reset();
        test_single();
        test_overflow();
        drain(4);
        test_fence();
        test_stall();
        drain(4);
        test_wrap();
        drain(4);
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
